// File: rtl/uart_rx_char.sv
// uart_rx_char: 8N1 serial receiver that feeds the ASCII case converter.
// It synchronizes rxd, times every bit from the middle of the start bit,
// and holds the last good byte on char_out. The byte is marked with a
// one-cycle char_valid pulse. A low stop bit gives a one-cycle frame_err
// pulse, and the receiver then waits for the line to go idle again.
module uart_rx_char #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       char_next;
    logic             valid_next;
    logic             err_next;
    logic             s1, rxs;

    // Two-flop synchronizer for the asynchronous line; it resets to the idle level.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples its inputs from before the edge, whatever the statement order.
        if (rst) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= rxd;
            rxs <= s1;
        end
    end

    // State, counters, data path and output strobes. Reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            shift      <= shift_next;
            char_out   <= char_next;
            char_valid <= valid_next;
            frame_err  <= err_next;
        end
    end

    // Next-state logic. Timing starts from the middle of the start bit, and each
    // later sample is taken a full bit period after the one before.
    always_comb begin
        // NOTE: every signal gets a default value first. A path that does not
        // assign a signal then keeps this value, so no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        char_next  = char_out;
        valid_next = 1'b0;
        err_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        // The line went high again before mid-bit, so this was a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[7:1]};
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        char_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            BREAK: begin
                // A long low line gives only one error. Wait here until the line is idle.
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
